serial_adder: RTL

//  Bit-serial N-bit adder stage feeding the team's half-adder cells: accepts two operands plus carry-in

---
 rtl/serial_arith_pkg.sv | 10 +
 rtl/serial_fa_cell.sv | 16 +
 rtl/serial_adder.sv | 93 +++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state encoding and width limits for the bit-serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder built from two half-adder stages and an OR
// Ports: a, b, ci (in) operand bits and carry-in; s (out) sum bit; co (out) carry-out
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;
  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock, valid/ready on both sides
// Ports: clk, rst (async, active-high); in_valid/in_ready with a, b, cin sampled on accept;
//        out_valid/out_ready with sum, cout held from DONE entry until the next DONE;
//        busy high in RUN or DONE; ovf (signed overflow) only when SERIAL_ADDER_OVF_EN is defined
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end
  state_t state, nxt;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic [CW-1:0] cnt;
  logic carry, s, c, last;
  serial_fa_cell u_fa (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .ci(carry),
    .s (s),
    .co(c)
  );
  assign last      = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));
  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign busy      = state != ST_IDLE;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: nxt = in_valid ? ST_RUN : ST_IDLE;
      ST_RUN:  nxt = last ? ST_DONE : ST_RUN;
      ST_DONE: nxt = out_ready ? ST_IDLE : ST_DONE;
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= nxt;
      if (in_valid && in_ready) begin
        a_sr  <= a;
        b_sr  <= b;
        s_sr  <= '0;
        carry <= cin;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        s_sr  <= {s, s_sr[WIDTH-1:1]};
        carry <= c;
        cnt   <= last ? cnt : cnt + 1'b1;
      end
      // Outputs are published only on DONE entry, so they include the final bit directly
      if (last) begin
        sum  <= {s, s_sr[WIDTH-1:1]};
        cout <= c;
      end
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  // On the last RUN cycle carry holds the carry into the MSB and c is the carry out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (last) ovf <= carry ^ c;
  end
`endif
endmodule
